// File: rtl/ctrl_word_arbiter.sv
// ctrl_word_arbiter: round-robin arbiter sharing one 16-bit drive control word
// between up to four writers. Each grant applies a masked read-modify-write to
// the held word. The word is then frozen for HOLD cycles. A watchdog forces
// SAFE_WORD when no write has been accepted for TIMEOUT cycles.
module ctrl_word_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned HOLD      = 8,
    parameter int unsigned TIMEOUT   = 50000,
    parameter logic [15:0] SAFE_WORD = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [16*N_REQ-1:0] wdata,
    input  logic [16*N_REQ-1:0] wmask,
    output logic [N_REQ-1:0]    gnt,
    output logic [15:0]         WordOut,
    output logic                wr_done,
    output logic                busy,
    output logic                timeout
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned HW = $clog2(HOLD + 1);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [15:0]      word_q, word_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             done_q, done_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic             timeout_q, timeout_d;

    logic             pick_valid;
    logic [PW-1:0]    pick_idx;
    logic [PW-1:0]    cand;
    logic [15:0]      sel_data;
    logic [15:0]      sel_mask;
    logic             grant;

    // Round-robin pick: first active requester at or after the pointer, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = 0; off < int'(N_REQ); off++) begin
            cand = PW'((int'(ptr_q) + off) % int'(N_REQ));
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Data and mask lanes of the selected writer.
    always_comb begin
        sel_data = wdata[16*pick_idx +: 16];
        sel_mask = wmask[16*pick_idx +: 16];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave IDLE on any request, leave HOLD on the last hold cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (hold_q == HW'(1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: requests are only accepted in IDLE; HOLD is reported as busy.
    always_comb begin
        busy  = (state_q == StHold);
        grant = (state_q == StIdle) && pick_valid;
    end

    // Datapath next state: watchdog, hold countdown, and the masked write on grant.
    always_comb begin
        word_d    = word_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        wd_d      = wd_q;
        timeout_d = timeout_q;

        // Saturating watchdog; expiry fires once, on the step that reaches TIMEOUT.
        if (wd_q != WW'(TIMEOUT)) begin
            wd_d = wd_q + WW'(1);
        end
        if (wd_q == WW'(TIMEOUT - 1)) begin
            word_d    = SAFE_WORD;
            timeout_d = 1'b1;
        end

        if (state_q == StHold && hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end

        // A write on the expiry cycle overrides the safe word and the timeout flag.
        if (grant) begin
            word_d          = (word_q & ~sel_mask) | (sel_data & sel_mask);
            gnt_d[pick_idx] = 1'b1;
            done_d          = 1'b1;
            ptr_d           = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + PW'(1);
            hold_d          = HW'(HOLD);
            wd_d            = '0;
            timeout_d       = 1'b0;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q    <= SAFE_WORD;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            word_q    <= word_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign WordOut = word_q;
    assign wr_done = done_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_ctrl_word_arbiter.sv
// Testbench for ctrl_word_arbiter: directed stimulus; expected grants (writer,
// resulting word, visible cycle) are queued when requests are driven and are
// matched by a negedge monitor whenever the DUT pulses gnt.
module tb_ctrl_word_arbiter;

    localparam int unsigned NR   = 4;
    localparam int unsigned HLD  = 8;
    localparam int unsigned TOUT = 100;

    bit           clk;
    logic         rst;
    logic [3:0]   req;
    logic [63:0]  wdata;
    logic [63:0]  wmask;
    logic [3:0]   gnt;
    logic [15:0]  WordOut;
    logic         wr_done;
    logic         busy;
    logic         timeout;

    ctrl_word_arbiter #(
        .N_REQ    (NR),
        .HOLD     (HLD),
        .TIMEOUT  (TOUT),
        .SAFE_WORD(16'h0000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .wdata  (wdata),
        .wmask  (wmask),
        .gnt    (gnt),
        .WordOut(WordOut),
        .wr_done(wr_done),
        .busy   (busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  g;
        logic [15:0] w;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   busy_run = 0;
    logic prev_busy = 1'b0;
    int   base;
    int   g;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_writer(input int i, input logic [15:0] d, input logic [15:0] m);
        wdata[16*i +: 16] = d;
        wmask[16*i +: 16] = m;
    endtask

    task automatic push(input logic [3:0] gv, input logic [15:0] wv, input int at);
        exp_t x;
        x.g  = gv;
        x.w  = wv;
        x.at = at;
        sb.push_back(x);
    endtask

    // Monitor: match grants against the scoreboard and check busy/wr_done behaviour.
    always @(negedge clk) begin
        if (gnt != 4'b0000) begin
            check_eq("gnt_after_busy", {31'b0, prev_busy}, 32'd0);
            if (sb.size() == 0) begin
                check_eq("unexpected_gnt", {28'b0, gnt}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("gnt", {28'b0, gnt}, {28'b0, e.g});
                check_eq("gnt_word", {16'b0, WordOut}, {16'b0, e.w});
                check_eq("gnt_cycle", cyc, e.at);
                check_eq("busy_at_gnt", {31'b0, busy}, 32'd1);
            end
        end
        if (gnt != 4'b0000 || wr_done) begin
            check_eq("wr_done_coinc", {31'b0, wr_done}, {31'b0, |gnt});
        end
        if (rst) begin
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            check_eq("busy_len", busy_run, HLD);
            busy_run = 0;
        end
        prev_busy = busy;
    end

    initial begin
        #100000;
        $display("FAIL tb_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "tb time limit");
    end

    initial begin
        rst   = 1'b1;
        req   = 4'b1111;
        wdata = '0;
        wmask = '0;
        set_writer(0, 16'h1200, 16'hFFF0);
        set_writer(1, 16'hABCD, 16'h0000);
        set_writer(2, 16'hFFFF, 16'h00F0);
        set_writer(3, 16'h0005, 16'h000F);

        // Reset held for 3 cycles with all requests high.
        tick(3);
        check_eq("rst_word", {16'b0, WordOut}, 32'h0000);
        check_eq("rst_gnt", {28'b0, gnt}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, wr_done}, 32'd0);
        check_eq("rst_timeout", {31'b0, timeout}, 32'd0);

        // Round-robin with all four requesting: grants every HOLD+1 cycles.
        rst  = 1'b0;
        base = cyc;
        push(4'b0001, 16'h1200, base + 1);
        push(4'b0010, 16'h1200, base + 10);
        push(4'b0100, 16'h12F0, base + 19);
        push(4'b1000, 16'h12F5, base + 28);
        push(4'b0001, 16'h1205, base + 37);
        tick(37);
        req = 4'b0000;
        tick(10);

        // Withdrawal: writer 1 raises and drops req entirely within HOLD.
        set_writer(0, 16'h00A0, 16'h00F0);
        req = 4'b0001;
        push(4'b0001, 16'h12A5, cyc + 1);
        tick(1);
        req = 4'b0000;
        tick(2);
        req = 4'b0010;
        tick(3);
        req = 4'b0000;
        tick(6);
        check_eq("withdraw_busy", {31'b0, busy}, 32'd0);

        // Zero mask: grant pulses, word unchanged.
        set_writer(3, 16'hFFFF, 16'h0000);
        req = 4'b1000;
        push(4'b1000, 16'h12A5, cyc + 1);
        tick(1);
        req = 4'b0000;
        check_eq("zmask_word", {16'b0, WordOut}, 32'h12A5);
        tick(10);

        // Watchdog: single write, then idle until expiry.
        set_writer(0, 16'hA5A5, 16'hFFFF);
        req = 4'b0001;
        push(4'b0001, 16'hA5A5, cyc + 1);
        tick(1);
        req = 4'b0000;
        tick(99);
        check_eq("wd_pre_word", {16'b0, WordOut}, 32'hA5A5);
        check_eq("wd_pre_flag", {31'b0, timeout}, 32'd0);
        tick(1);
        check_eq("wd_word", {16'b0, WordOut}, 32'h0000);
        check_eq("wd_flag", {31'b0, timeout}, 32'd1);
        tick(10);
        check_eq("wd_sticky", {31'b0, timeout}, 32'd1);
        check_eq("wd_sticky_word", {16'b0, WordOut}, 32'h0000);

        // Write after expiry clears the flag.
        set_writer(1, 16'h0001, 16'hFFFF);
        req = 4'b0010;
        push(4'b0010, 16'h0001, cyc + 1);
        tick(1);
        req = 4'b0000;
        g = cyc;
        check_eq("wd_clear_flag", {31'b0, timeout}, 32'd0);
        check_eq("wd_clear_word", {16'b0, WordOut}, 32'h0001);

        // Grant on the exact expiry edge: the write wins.
        tick(99);
        check_eq("sim_pre_flag", {31'b0, timeout}, 32'd0);
        set_writer(2, 16'h3C3C, 16'hFFFF);
        req = 4'b0100;
        push(4'b0100, 16'h3C3C, g + 100);
        tick(1);
        req = 4'b0000;
        check_eq("sim_word", {16'b0, WordOut}, 32'h3C3C);
        check_eq("sim_flag", {31'b0, timeout}, 32'd0);
        tick(60);
        check_eq("sim_after_word", {16'b0, WordOut}, 32'h3C3C);
        check_eq("sim_after_flag", {31'b0, timeout}, 32'd0);

        // Reset 3 cycles into HOLD; pointer (now 2) must restart at 0.
        set_writer(1, 16'h1234, 16'hFFFF);
        req = 4'b0010;
        push(4'b0010, 16'h1234, cyc + 1);
        tick(1);
        req = 4'b0000;
        tick(3);
        rst = 1'b1;
        tick(1);
        check_eq("mid_rst_busy", {31'b0, busy}, 32'd0);
        check_eq("mid_rst_word", {16'b0, WordOut}, 32'h0000);
        check_eq("mid_rst_gnt", {28'b0, gnt}, 32'd0);
        check_eq("mid_rst_flag", {31'b0, timeout}, 32'd0);
        rst = 1'b0;
        req = 4'b1111;
        push(4'b0001, 16'hA5A5, cyc + 1);
        tick(1);
        req = 4'b0000;
        tick(12);

        check_eq("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
